// File: rtl/dccm_arbiter.sv
// dccm_arbiter
// Shares one single-port DFFRAM data memory between two SRAM-style requesters.
// Two-way round-robin arbitration, bit-mask to byte-enable conversion,
// read-response routing back to the issuing port, out-of-range flagging.
//
// Ports:
//   clock, reset            clock, asynchronous active-low reset
//   req_i[1:0], we_i[1:0]   per-port request / write enable (bit n = port n)
//   addr*_i, wdata*_i       per-port word address and write data
//   wmask*_i                per-port bit write mask
//   gnt_o[1:0]              per-port grant (combinational)
//   rvalid_o[1:0]           per-port read response valid
//   rdata*_o, rerror*_o     per-port read data / read error (2'b11 = out of range)
//   mem_en_o, mem_we_o      DFFRAM chip enable / byte write enables
//   mem_a_o, mem_di_o       DFFRAM address / write data
//   mem_do_i                DFFRAM read data, valid the cycle after an enabled read
module dccm_arbiter #(
    parameter int AW    = 12,
    parameter int DW    = 32,
    parameter int Depth = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [AW-1:0]     addr0_i,
    input  logic [AW-1:0]     addr1_i,
    input  logic [DW-1:0]     wdata0_i,
    input  logic [DW-1:0]     wdata1_i,
    input  logic [DW-1:0]     wmask0_i,
    input  logic [DW-1:0]     wmask1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DW-1:0]     rdata0_o,
    output logic [DW-1:0]     rdata1_o,
    output logic [1:0]        rerror0_o,
    output logic [1:0]        rerror1_o,
    output logic              mem_en_o,
    output logic [DW/8-1:0]   mem_we_o,
    output logic [AW-1:0]     mem_a_o,
    output logic [DW-1:0]     mem_di_o,
    input  logic [DW-1:0]     mem_do_i
);

    localparam int BW = DW / 8;
    // One extra bit so Depth == 2**AW is representable in the range compare.
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(Depth);

    // A byte lane is written when any bit of its mask slice is set.
    function automatic logic [BW-1:0] mask_to_be(input logic [DW-1:0] mask);
        logic [BW-1:0] be;
        be = '0;
        for (int b = 0; b < BW; b++) begin
            be[b] = |mask[8*b +: 8];
        end
        return be;
    endfunction

    logic [1:0]    gnt_s;
    logic          any_gnt_s;
    logic          sel_s;        // index of the granted port (0 when idle)
    logic          we_sel_s;
    logic [AW-1:0] addr_sel_s;
    logic [DW-1:0] wdata_sel_s;
    logic [DW-1:0] wmask_sel_s;
    logic          in_range_s;

    logic          last_r;       // port granted most recently; reset to 1 so port 0 wins first
    logic          tag_valid_r;
    logic          tag_port_r;
    logic          tag_oor_r;

    // Round-robin grant: on contention the port not granted most recently wins.
    always_comb begin
        gnt_s = 2'b00;
        case (req_i)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = last_r ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
        endcase
    end

    // Mux the granted port's request onto the memory side.
    always_comb begin
        any_gnt_s   = |gnt_s;
        sel_s       = gnt_s[1];
        if (sel_s) begin
            we_sel_s    = we_i[1];
            addr_sel_s  = addr1_i;
            wdata_sel_s = wdata1_i;
            wmask_sel_s = wmask1_i;
        end else begin
            we_sel_s    = we_i[0];
            addr_sel_s  = addr0_i;
            wdata_sel_s = wdata0_i;
            wmask_sel_s = wmask0_i;
        end
        in_range_s  = ({1'b0, addr_sel_s} < DEPTH_L);
    end

    // Memory drive: out-of-range accesses keep the RAM idle, dropping writes.
    always_comb begin
        mem_a_o  = addr_sel_s;
        mem_di_o = wdata_sel_s;
        if (any_gnt_s && in_range_s) begin
            mem_en_o = 1'b1;
            if (we_sel_s) begin
                mem_we_o = mask_to_be(wmask_sel_s);
            end else begin
                mem_we_o = {BW{1'b0}};
            end
        end else begin
            mem_en_o = 1'b0;
            mem_we_o = {BW{1'b0}};
        end
    end

    // Priority pointer follows every grant; holds when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_r <= 1'b1;
        end else if (any_gnt_s) begin
            last_r <= sel_s;
        end else begin
            last_r <= last_r;
        end
    end

    // In-flight read tag; reset clears it so a pending response is discarded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid_r <= 1'b0;
            tag_port_r  <= 1'b0;
            tag_oor_r   <= 1'b0;
        end else begin
            tag_valid_r <= any_gnt_s & ~we_sel_s;
            tag_port_r  <= sel_s;
            tag_oor_r   <= ~in_range_s;
        end
    end

    // Response routing: only the responding port sees data/error; the other holds 0.
    always_comb begin
        gnt_o     = gnt_s;
        rvalid_o  = 2'b00;
        rdata0_o  = {DW{1'b0}};
        rdata1_o  = {DW{1'b0}};
        rerror0_o = 2'b00;
        rerror1_o = 2'b00;
        if (tag_valid_r) begin
            if (tag_port_r) begin
                rvalid_o  = 2'b10;
                rdata1_o  = tag_oor_r ? {DW{1'b0}} : mem_do_i;
                rerror1_o = tag_oor_r ? 2'b11 : 2'b00;
            end else begin
                rvalid_o  = 2'b01;
                rdata0_o  = tag_oor_r ? {DW{1'b0}} : mem_do_i;
                rerror0_o = tag_oor_r ? 2'b11 : 2'b00;
            end
        end else begin
            rvalid_o = 2'b00;
        end
    end

endmodule

// File: tb/tb_dccm_arbiter.sv
// Directed self-checking bench for dccm_arbiter (Depth = 1024) with a
// behavioural 1-cycle-latency byte-writable RAM model.
module tb_dccm_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  we_i = 2'b00;
    logic [11:0] addr0_i = 12'h000;
    logic [11:0] addr1_i = 12'h000;
    logic [31:0] wdata0_i = 32'h0;
    logic [31:0] wdata1_i = 32'h0;
    logic [31:0] wmask0_i = 32'h0;
    logic [31:0] wmask1_i = 32'h0;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata0_o;
    logic [31:0] rdata1_o;
    logic [1:0]  rerror0_o;
    logic [1:0]  rerror1_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [11:0] mem_a_o;
    logic [31:0] mem_di_o;
    logic [31:0] mem_do_i = 32'h0;

    logic [31:0] mem [0:1023];
    int n_cmp = 0;
    int n_err = 0;

    dccm_arbiter #(.AW(12), .DW(32), .Depth(1024)) dut (
        .clock(clock), .reset(reset), .req_i(req_i), .we_i(we_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .wmask0_i(wmask0_i), .wmask1_i(wmask1_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata0_o(rdata0_o), .rdata1_o(rdata1_o), .rerror0_o(rerror0_o), .rerror1_o(rerror1_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_a_o(mem_a_o), .mem_di_o(mem_di_o),
        .mem_do_i(mem_do_i)
    );

    always #5 clock = ~clock;

    // RAM model: read-before-write, byte write enables, 1-cycle read latency.
    always @(posedge clock) begin
        if (mem_en_o) begin
            mem_do_i <= mem[mem_a_o[9:0]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o[b]) mem[mem_a_o[9:0]][8*b +: 8] <= mem_di_o[8*b +: 8];
            end
        end
    end

    task automatic idle();
        req_i = 2'b00; we_i = 2'b00;
        wmask0_i = 32'h0; wmask1_i = 32'h0;
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #3;
        n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL reset_rvalid got=%b exp=00", rvalid_o); end
        n_cmp++; if (mem_en_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_en got=%b exp=0", mem_en_o); end
        n_cmp++; if ({rdata0_o, rdata1_o, rerror0_o, rerror1_o} !== 68'h0) begin n_err++; $display("FAIL reset_rdata got=%h/%h/%b/%b exp=0", rdata0_o, rdata1_o, rerror0_o, rerror1_o); end
        step();
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        step();
        req_i = 2'b01; we_i = 2'b01; addr0_i = 12'h010; wdata0_i = 32'hDEADBEEF; wmask0_i = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL wr_gnt got=%b exp=01", gnt_o); end
        n_cmp++; if (mem_we_o !== 4'hF) begin n_err++; $display("FAIL wr_mem_we got=%h exp=f", mem_we_o); end
        n_cmp++; if (mem_a_o !== 12'h010 || mem_en_o !== 1'b1) begin n_err++; $display("FAIL wr_mem_a got=%h en=%b exp=010 en=1", mem_a_o, mem_en_o); end
        step();
        n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL wr_no_rvalid got=%b exp=00", rvalid_o); end
        req_i = 2'b10; we_i = 2'b00; addr1_i = 12'h010; wmask0_i = 32'h0;
        #1;
        n_cmp++; if (gnt_o !== 2'b10) begin n_err++; $display("FAIL rd_gnt got=%b exp=10", gnt_o); end
        step();
        idle();
        n_cmp++; if (rvalid_o !== 2'b10) begin n_err++; $display("FAIL rd_rvalid got=%b exp=10", rvalid_o); end
        n_cmp++; if (rdata1_o !== 32'hDEADBEEF || rerror1_o !== 2'b00) begin n_err++; $display("FAIL rd_data got=%h err=%b exp=deadbeef err=00", rdata1_o, rerror1_o); end
        n_cmp++; if (rdata0_o !== 32'h0) begin n_err++; $display("FAIL rd_other_port got=%h exp=0", rdata0_o); end
    endtask

    task automatic test_round_robin();
        logic [1:0] prev;
        logic [1:0] exp_g;
        mem[12'h020] = 32'hA0A0A0A0;
        mem[12'h021] = 32'hA1A1A1A1;
        test_reset();
        prev = 2'b00;
        for (int k = 0; k < 7; k++) begin
            step();
            if (k > 0) begin
                n_cmp++; if (rvalid_o !== prev) begin n_err++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", k, rvalid_o, prev); end
                if (prev == 2'b01) begin
                    n_cmp++; if (rdata0_o !== 32'hA0A0A0A0) begin n_err++; $display("FAIL rr_rdata0[%0d] got=%h exp=a0a0a0a0", k, rdata0_o); end
                end else begin
                    n_cmp++; if (rdata1_o !== 32'hA1A1A1A1) begin n_err++; $display("FAIL rr_rdata1[%0d] got=%h exp=a1a1a1a1", k, rdata1_o); end
                end
            end
            if (k < 6) begin
                req_i = 2'b11; we_i = 2'b00; addr0_i = 12'h020; addr1_i = 12'h021;
                #1;
                exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
                n_cmp++; if (gnt_o !== exp_g) begin n_err++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt_o, exp_g); end
                prev = exp_g;
            end else begin
                idle();
            end
        end
    endtask

    task automatic test_byte_enable();
        mem[12'h030] = 32'hAAAAAAAA;
        step();
        req_i = 2'b01; we_i = 2'b01; addr0_i = 12'h030; wdata0_i = 32'h12345678; wmask0_i = 32'h00FF00F0;
        #1;
        n_cmp++; if (mem_we_o !== 4'b0101) begin n_err++; $display("FAIL be_mem_we got=%b exp=0101", mem_we_o); end
        step();
        wmask0_i = 32'h0; wdata0_i = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (mem_en_o !== 1'b1 || mem_we_o !== 4'b0000) begin n_err++; $display("FAIL be_zero_mask got en=%b we=%b exp en=1 we=0000", mem_en_o, mem_we_o); end
        step();
        n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL be_zero_mask_rvalid got=%b exp=00", rvalid_o); end
        we_i = 2'b00;
        step();
        idle();
        n_cmp++; if (rvalid_o !== 2'b01 || rdata0_o !== 32'hAA34AA78) begin n_err++; $display("FAIL be_readback got=%b/%h exp=01/aa34aa78", rvalid_o, rdata0_o); end
    endtask

    task automatic test_out_of_range();
        mem[12'h000] = 32'h11111111;
        step();
        req_i = 2'b10; we_i = 2'b00; addr1_i = 12'h400;
        #1;
        n_cmp++; if (gnt_o !== 2'b10 || mem_en_o !== 1'b0) begin n_err++; $display("FAIL oor_rd_drive got gnt=%b en=%b exp gnt=10 en=0", gnt_o, mem_en_o); end
        step();
        n_cmp++; if (rvalid_o !== 2'b10 || rerror1_o !== 2'b11 || rdata1_o !== 32'h0) begin n_err++; $display("FAIL oor_rd_resp got=%b/%b/%h exp=10/11/0", rvalid_o, rerror1_o, rdata1_o); end
        we_i = 2'b10; wdata1_i = 32'hFFFFFFFF; wmask1_i = 32'hFFFFFFFF;
        #1;
        n_cmp++; if (mem_en_o !== 1'b0 || mem_we_o !== 4'h0 || gnt_o !== 2'b10) begin n_err++; $display("FAIL oor_wr_drive got en=%b we=%h gnt=%b exp en=0 we=0 gnt=10", mem_en_o, mem_we_o, gnt_o); end
        step();
        we_i = 2'b00; wmask1_i = 32'h0; addr1_i = 12'h3FF;
        #1;
        n_cmp++; if (mem_en_o !== 1'b1) begin n_err++; $display("FAIL oor_last_word_en got=%b exp=1", mem_en_o); end
        step();
        n_cmp++; if (rerror1_o !== 2'b00) begin n_err++; $display("FAIL oor_last_word_err got=%b exp=00", rerror1_o); end
        addr1_i = 12'h000;
        step();
        idle();
        n_cmp++; if (rvalid_o !== 2'b10 || rdata1_o !== 32'h11111111) begin n_err++; $display("FAIL oor_wr_dropped got=%b/%h exp=10/11111111", rvalid_o, rdata1_o); end
    endtask

    task automatic test_reset_mid();
        step();
        req_i = 2'b01; we_i = 2'b00; addr0_i = 12'h010;
        #1;
        n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL rm_gnt got=%b exp=01", gnt_o); end
        #1;
        reset = 1'b0;
        idle();
        step();
        n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL rm_rvalid got=%b exp=00", rvalid_o); end
        reset = 1'b1;
        req_i = 2'b10; addr1_i = 12'h010;
        #1;
        n_cmp++; if (gnt_o !== 2'b10) begin n_err++; $display("FAIL rm_single_p1 got=%b exp=10", gnt_o); end
        step();
        req_i = 2'b11; addr0_i = 12'h010;
        #1;
        n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL rm_ptr_p0 got=%b exp=01", gnt_o); end
        step();
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        for (int i = 1; i <= 4; i++) mem[i] = 32'hB0000000 + 32'(i);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k > 0) begin
                exp_d = 32'hB0000000 + 32'(k);
                n_cmp++; if (rvalid_o !== 2'b10 || rdata1_o !== exp_d) begin n_err++; $display("FAIL b2b_resp[%0d] got=%b/%h exp=10/%h", k, rvalid_o, rdata1_o, exp_d); end
            end
            if (k < 4) begin
                req_i = 2'b10; we_i = 2'b00; addr1_i = 12'(k + 1);
                #1;
                n_cmp++; if (gnt_o !== 2'b10) begin n_err++; $display("FAIL b2b_gnt[%0d] got=%b exp=10", k, gnt_o); end
            end else begin
                idle();
            end
        end
        step();
        n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL b2b_idle got=%b exp=00", rvalid_o); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_byte_enable();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dccm_arbiter.md
Name: dccm_arbiter

Overview:
- Shares one single-port DFFRAM data memory (12-bit word address, 32-bit data, 4-bit byte write enable, 1-cycle read latency) between two SRAM-style requesters, e.g. two tlul_sram_adapter instances for core data port and debug/DMA port.
- Does round-robin arbitration, converts bit write masks to byte enables, routes each read response back to its issuer, and flags out-of-range accesses.

Parameters:
- AW, 12, word address width
- DW, 32, data width (fixed multiple of 8)
- Depth, 4096, number of implemented words; word addresses >= Depth are out of range

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- req_i  in  2  per-port request, bit n = port n
- we_i  in  2  per-port write enable
- addr0_i / addr1_i  in  AW  per-port word address
- wdata0_i / wdata1_i  in  DW  per-port write data
- wmask0_i / wmask1_i  in  DW  per-port bit write mask
- gnt_o  out  2  per-port grant (combinational)
- rvalid_o  out  2  per-port read response valid
- rdata0_o / rdata1_o  out  DW  per-port read data
- rerror0_o / rerror1_o  out  2  per-port read error
- mem_en_o  out  1  DFFRAM chip enable
- mem_we_o  out  DW/8  DFFRAM byte write enables
- mem_a_o  out  AW  DFFRAM address
- mem_di_o  out  DW  DFFRAM write data
- mem_do_i  in  DW  DFFRAM read data, valid the cycle after an enabled read

Behaviour:
- Reset (reset=0, asynchronous): rvalid_o=0, rerror*=0, rdata*=0, pointer favours port 0, in-flight read tracking cleared. A response pending at reset is discarded, never delivered.
- gnt_o is combinational:
  - Only one port requests: that port is granted.
  - Both request: grant the port not granted most recently.
  - At most one gnt_o bit is high per cycle.
  - A non-requesting port is never granted.
- Priority pointer updates on the clock edge of every grant to the granted port. No grant, no change. Single requester: back-to-back grants every cycle, no bubbles.
- A request is accepted in the cycle req & gnt. A denied request must hold its req/we/addr/wdata/wmask stable until granted. The arbiter stores nothing for denied requests.
- Memory drive, same cycle as grant, muxed from the granted port:
  - mem_en_o = granted & in-range.
  - mem_a_o = addr; mem_di_o = wdata.
  - mem_we_o[b] = we & (|wmask[8b+7:8b]).
  - No grant: mem_en_o=0, mem_we_o=0, mem_a_o/mem_di_o = port 0 values (don't-care).
- Write with all-zero mask: mem_en_o=1, mem_we_o=0. This is a harmless read cycle and produces no response.
- Writes never produce rvalid_o.
- Reads:
  - Registered tag {valid, port, oor} captured at grant.
  - Next cycle: rvalid_o[port]=1 for exactly one cycle.
  - rdata<port>_o = mem_do_i (0 if oor).
  - rerror<port>_o = 2'b00 (2'b11 if oor).
  - rdata/rerror of a port not currently responding hold 0.
- Out-of-range (addr >= Depth): still granted and consumes the arbitration slot. mem_en_o=0. Writes are dropped silently; reads return error as above.
- Pipelining: a new grant may issue in the same cycle a previous read response is presented. Throughput is one access per cycle total.
- Back-to-back read responses may alternate ports cycle by cycle.
- Simultaneous read response and new read to the same port: both handled; the response belongs to the prior request.

Test Plan:
- Reset → rvalid_o=0, mem_en_o=0. Port0 write addr 0x010, wdata 0xDEADBEEF, wmask 0xFFFFFFFF → gnt_o=01, mem_we_o=4'hF, mem_a_o=0x010, no rvalid. Port1 read 0x010 next cycle → gnt_o=10, following cycle rvalid_o=10, rdata1_o=0xDEADBEEF, rerror1_o=0.
- Both ports read continuously for 6 cycles after reset → gnt_o sequence 01,10,01,10,01,10. Each rvalid_o one cycle after its grant; no port starves.
- Port0 write wmask 0x00FF00F0, we=1 → mem_we_o=4'b0101. Write wmask 0 → mem_en_o=1, mem_we_o=0, no response.
- Depth=1024, port1 read addr 0x400 → gnt_o=10, mem_en_o=0, next cycle rvalid_o=10, rerror1_o=2'b11, rdata1_o=0. Port1 write 0x400 → mem_en_o=0, memory unchanged on readback.
- Port0 read granted, reset asserted mid-cycle before the response edge → rvalid_o stays 0. After release, port1-only request is granted first cycle (gnt_o=10); pointer then favours port0.
- Single requester port1 issuing 4 consecutive reads at 0x001..0x004 → gnt_o=10 every cycle, 4 consecutive rvalid_o=10 cycles with data in order.
